// File: rtl/uart_pkg.sv
// ============================================================================
// uart_pkg : shared state encoding, parity constants and width helper.  Rev 1.0
// ============================================================================
`default_nettype none

package uart_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      DATA      = 3'd2,
      PARITY    = 3'd3,
      STOP      = 3'd4,
      WAIT_HIGH = 3'd5
   } rx_state_t;

   localparam logic PARITY_EVEN = 1'b0;
   localparam logic PARITY_ODD  = 1'b1;

   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int i = 0; i < 32; i++) begin
         if ((1 << result) < value) begin
            result = result + 1;
         end
      end
      return (result < 1) ? 1 : result;
   endfunction

endpackage

`default_nettype wire

// File: rtl/uart_rx_param_if.sv
// ============================================================================
// uart_rx_param_if : frame delivery handshake with status flags.  Rev 1.0
// ============================================================================
`default_nettype none

interface uart_rx_param_if #(
   parameter int DATA_LENGTH = 8
);
   logic [DATA_LENGTH-1:0] parallel_dataout;
   logic                   data_valid;
   logic                   data_ready;
   logic                   parity_error;
   logic                   frame_error;
   logic                   break_detect;
   logic                   overrun_error;

   modport master (
      output parallel_dataout,
      output data_valid,
      output parity_error,
      output frame_error,
      output break_detect,
      output overrun_error,
      input  data_ready
   );

   modport slave (
      input  parallel_dataout,
      input  data_valid,
      input  parity_error,
      input  frame_error,
      input  break_detect,
      input  overrun_error,
      output data_ready
   );
endinterface

`default_nettype wire

// File: rtl/uart_rx_sampler.sv
// ============================================================================
// uart_rx_sampler : 2-flop synchroniser, 3-tap majority vote, fall detect. Rev 1.0
// ============================================================================
`default_nettype none

module uart_rx_sampler (
   input  logic clk,
   input  logic rst,
   input  logic serial_in,
   output logic sample,
   output logic fall_edge
);
   logic       r_sync1;
   logic       r_sync2;
   logic [1:0] r_hist;
   logic       r_prev_sample;

   // Everything resets to the idle-line level so reset release never looks like a start edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync1       <= 1'b1;
         r_sync2       <= 1'b1;
         r_hist        <= 2'b11;
         r_prev_sample <= 1'b1;
      end else begin
         r_sync1       <= serial_in;
         r_sync2       <= r_sync1;
         r_hist        <= {r_hist[0], r_sync2};
         r_prev_sample <= sample;
      end
   end

   assign sample    = (r_sync2 & r_hist[0]) | (r_sync2 & r_hist[1]) | (r_hist[0] & r_hist[1]);
   assign fall_edge = r_prev_sample & ~sample;

endmodule

`default_nettype wire

// File: rtl/uart_rx_param.sv
// ============================================================================
// uart_rx_param : parametrised oversampling UART receiver, valid/ready out. Rev 1.0
// ============================================================================
`default_nettype none

module uart_rx_param
   import uart_pkg::*;
#(
   parameter int DATA_LENGTH = 8,
   parameter int PARITY_EN   = 1,
   parameter int STOP_BITS   = 1,
   parameter int CLK_PER_BIT = 16
) (
   input  logic            rx_clk,
   input  logic            rst,
   input  logic            serialdata_in,
   input  logic            parity_type,
   output logic            rx_busy,
   uart_rx_param_if.master bus
);
   localparam int c_cnt_w = clog2(CLK_PER_BIT);
   localparam int c_bit_w = clog2(DATA_LENGTH + 1);
   localparam logic [c_cnt_w-1:0] c_mid       = c_cnt_w'(CLK_PER_BIT / 2);
   localparam logic [c_cnt_w-1:0] c_last      = c_cnt_w'(CLK_PER_BIT - 1);
   localparam logic [c_bit_w-1:0] c_data_last = c_bit_w'(DATA_LENGTH - 1);
   localparam logic [c_bit_w-1:0] c_stop_last = c_bit_w'(STOP_BITS - 1);

   rx_state_t              r_state;
   logic [c_cnt_w-1:0]     r_cnt;
   logic [c_bit_w-1:0]     r_bitcnt;
   logic [DATA_LENGTH-1:0] r_shift;
   logic                   r_par_bit;
   logic                   r_perr;
   logic                   r_ferr;

   logic w_sample;
   logic w_fall;
   logic w_tick;
   logic w_break;
   logic w_done;
   logic w_done_ferr;

   uart_rx_sampler u_sampler (
      .clk       (rx_clk),
      .rst       (rst),
      .serial_in (serialdata_in),
      .sample    (w_sample),
      .fall_edge (w_fall)
   );

   // A break is only recognised on the first stop bit; it ends the frame early.
   always_comb begin
      w_tick      = (r_cnt == c_last);
      w_break     = (r_state == STOP) && w_tick && (r_bitcnt == '0) && !w_sample &&
                    (r_shift == '0) && ((PARITY_EN == 0) || !r_par_bit);
      w_done      = (r_state == STOP) && w_tick && (w_break || (r_bitcnt == c_stop_last));
      w_done_ferr = r_ferr | ~w_sample;
   end

   assign rx_busy = (r_state != IDLE);

   always_ff @(posedge rx_clk or posedge rst) begin
      if (rst) begin
         r_state              <= IDLE;
         r_cnt                <= '0;
         r_bitcnt             <= '0;
         r_shift              <= '0;
         r_par_bit            <= 1'b0;
         r_perr               <= 1'b0;
         r_ferr               <= 1'b0;
         bus.parallel_dataout <= '0;
         bus.data_valid       <= 1'b0;
         bus.parity_error     <= 1'b0;
         bus.frame_error      <= 1'b0;
         bus.break_detect     <= 1'b0;
         bus.overrun_error    <= 1'b0;
      end else begin
         bus.overrun_error <= 1'b0;
         // A held frame is never overwritten unless it is being accepted this cycle.
         if (w_done) begin
            if (!bus.data_valid || bus.data_ready) begin
               bus.parallel_dataout <= r_shift;
               bus.parity_error     <= r_perr;
               bus.frame_error      <= w_done_ferr;
               bus.break_detect     <= w_break;
               bus.data_valid       <= 1'b1;
            end else begin
               bus.overrun_error <= 1'b1;
            end
         end else if (bus.data_valid && bus.data_ready) begin
            bus.data_valid <= 1'b0;
         end

         case (r_state)
            IDLE: begin
               if (w_fall) begin
                  r_cnt   <= '0;
                  r_state <= START;
               end
            end
            START: begin
               if (r_cnt == c_mid) begin
                  r_cnt <= '0;
                  if (w_sample) begin
                     r_state <= IDLE;
                  end else begin
                     r_bitcnt <= '0;
                     r_perr   <= 1'b0;
                     r_ferr   <= 1'b0;
                     r_state  <= DATA;
                  end
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            DATA: begin
               r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
               if (w_tick) begin
                  r_shift <= {w_sample, r_shift[DATA_LENGTH-1:1]};
                  if (r_bitcnt == c_data_last) begin
                     r_bitcnt <= '0;
                     r_state  <= (PARITY_EN != 0) ? PARITY : STOP;
                  end else begin
                     r_bitcnt <= r_bitcnt + 1'b1;
                  end
               end
            end
            PARITY: begin
               r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
               if (w_tick) begin
                  r_par_bit <= w_sample;
                  r_perr    <= (^r_shift) ^ w_sample ^ parity_type;
                  r_state   <= STOP;
               end
            end
            STOP: begin
               r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
               if (w_tick) begin
                  r_ferr <= w_done_ferr;
                  if (w_break) begin
                     r_state <= WAIT_HIGH;
                  end else if (r_bitcnt == c_stop_last) begin
                     r_state <= IDLE;
                  end else begin
                     r_bitcnt <= r_bitcnt + 1'b1;
                  end
               end
            end
            WAIT_HIGH: begin
               if (w_sample) begin
                  r_state <= IDLE;
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_param.sv
// ============================================================================
// tb_uart_rx_param : directed + randomized frames against a frame-level model. Rev 1.0
// ============================================================================
`default_nettype none

module tb_uart_rx_param;
   import uart_pkg::*;

   localparam int DL    = 8;
   localparam int PE    = 1;
   localparam int SB    = 1;
   localparam int CPB   = 16;
   localparam int NBITS = 1 + DL + PE + SB;

   typedef struct {
      logic [DL-1:0] d;
      logic          perr;
      logic          ferr;
      logic          brk;
      bit            drop;
   } exp_t;

   logic clk    = 1'b0;
   logic rst    = 1'b1;
   logic serial = 1'b1;
   logic ptype  = 1'b0;
   logic busy;
   bit   ready_rand = 1'b0;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;
   int n_acc  = 0;
   int ovr_seen = 0;
   int t_start = 0;
   int t_valid = 0;
   int vrun = 0;
   int last_width = 0;
   logic [DL-1:0] last_data;
   logic [2:0]    last_flags;

   exp_t exp_q[$];
   exp_t cmp_e;
   bit   prev_valid = 1'b0;
   bit   prev_hold  = 1'b0;
   logic [DL+2:0] snap;
   logic [DL+2:0] cur;

   uart_rx_param_if #(.DATA_LENGTH(DL)) bus ();

   uart_rx_param #(
      .DATA_LENGTH (DL),
      .PARITY_EN   (PE),
      .STOP_BITS   (SB),
      .CLK_PER_BIT (CPB)
   ) dut (
      .rx_clk        (clk),
      .rst           (rst),
      .serialdata_in (serial),
      .parity_type   (ptype),
      .rx_busy       (busy),
      .bus           (bus)
   );

   always #5 clk = ~clk;

   initial begin
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   initial begin
      bus.data_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (ready_rand) bus.data_ready = 1'($urandom_range(0, 1));
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   task automatic check_range(input string name, input int act, input int lo, input int hi);
      checks++;
      if (act < lo || act > hi) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
      end
   endtask

   // Frame-level expectations straight from the line bits.
   function automatic exp_t model(input logic [DL-1:0] d, input logic p, input logic pt,
                                  input logic [1:0] st, input bit drop);
      exp_t e;
      e.d    = d;
      e.drop = drop;
      e.brk  = (d == '0) && (PE == 0 || p == 1'b0) && (st[0] == 1'b0);
      e.perr = (PE != 0) ? (^d ^ p ^ pt) : 1'b0;
      e.ferr = e.brk || !st[0] || (SB == 2 && !st[1]);
      return e;
   endfunction

   function automatic logic good_par(input logic [DL-1:0] d, input logic pt);
      return ^d ^ pt;
   endfunction

   // Compare process: checks every accepted frame, overrun pulse and held-data stability.
   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_valid = 1'b0;
            prev_hold  = 1'b0;
            vrun       = 0;
            continue;
         end
         cur = {bus.parity_error, bus.frame_error, bus.break_detect, bus.parallel_dataout};
         if (bus.overrun_error) begin
            bit ok;
            ovr_seen++;
            ok = (exp_q.size() >= 2) && exp_q[1].drop;
            check("overrun_expected", 32'(ok), 32'd1);
            if (ok) exp_q.delete(1);
         end
         if (prev_hold && bus.data_valid) check("hold_stable", 32'(cur), 32'(snap));
         if (bus.data_valid && bus.data_ready) begin
            bit ok;
            ok = (exp_q.size() > 0) && !exp_q[0].drop;
            check("frame_expected", 32'(ok), 32'd1);
            if (ok) begin
               cmp_e = exp_q.pop_front();
               check("frame_data", 32'(bus.parallel_dataout), 32'(cmp_e.d));
               check("frame_flags(perr,ferr,brk)",
                     32'({bus.parity_error, bus.frame_error, bus.break_detect}),
                     32'({cmp_e.perr, cmp_e.ferr, cmp_e.brk}));
            end
            last_data  = bus.parallel_dataout;
            last_flags = {bus.parity_error, bus.frame_error, bus.break_detect};
            n_acc++;
         end
         if (bus.data_valid && !prev_valid) t_valid = cyc;
         if (bus.data_valid) vrun++;
         else if (prev_valid) begin
            last_width = vrun;
            vrun = 0;
         end
         prev_valid = bus.data_valid;
         prev_hold  = bus.data_valid && !bus.data_ready;
         snap       = cur;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
      $fatal(1, "watchdog");
   end

   task automatic idle_bits(input int n);
      serial = 1'b1;
      repeat (n * CPB) @(negedge clk);
   endtask

   task automatic set_ready(input logic v);
      @(posedge clk);
      #1;
      bus.data_ready = v;
      @(negedge clk);
   endtask

   // Drives one frame bit-serially; glitch_bit inverts one cycle near its sample point, abort_bit stops early.
   task automatic send_frame(input logic [DL-1:0] d, input logic p, input logic [1:0] st,
                             input int glitch_bit, input int abort_bit);
      logic [NBITS-1:0] fr;
      fr[0] = 1'b0;
      for (int i = 0; i < DL; i++) fr[1+i] = d[i];
      if (PE != 0) fr[1+DL] = p;
      for (int j = 0; j < SB; j++) fr[1+DL+PE+j] = st[j];
      t_start = cyc;
      for (int k = 0; k < NBITS; k++) begin
         if (k == abort_bit) return;
         for (int c = 0; c < CPB; c++) begin
            serial = (k == glitch_bit && c == CPB / 2 + 2) ? ~fr[k] : fr[k];
            @(negedge clk);
         end
      end
   endtask

   task automatic tx(input logic [DL-1:0] d, input logic p, input logic [1:0] st,
                     input int gap, input bit drop);
      exp_q.push_back(model(d, p, ptype, st, drop));
      send_frame(d, p, st, -1, -1);
      idle_bits(gap);
   endtask

   task automatic wait_acc(input int target);
      int n;
      n = 0;
      while (n_acc < target && n < 4 * NBITS * CPB) begin
         @(negedge clk);
         n++;
      end
      check("accept_within_budget", 32'(n_acc >= target), 32'd1);
      repeat (2) @(negedge clk);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_valid"}, 32'(bus.data_valid), 32'd0);
      check({tag, "_data"}, 32'(bus.parallel_dataout), 32'd0);
      check({tag, "_flags"}, 32'({bus.parity_error, bus.frame_error, bus.break_detect, bus.overrun_error}), 32'd0);
      check({tag, "_busy"}, 32'(busy), 32'd0);
   endtask

   initial begin
      int base;
      int n;
      bit saw;
      logic [DL-1:0] d;
      logic p;
      logic [1:0] st;
      int gap;

      rst = 1'b1;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      rst = 1'b0;
      idle_bits(1);

      // Basic frame, consumer always ready.
      ptype = PARITY_EVEN;
      base = n_acc;
      tx(8'hA5, 1'b0, 2'b11, 1, 1'b0);
      wait_acc(base + 1);
      check("a5_data", 32'(last_data), 32'h0A5);
      check("a5_flags", 32'(last_flags), 32'd0);
      check_range("a5_valid_latency", t_valid - t_start,
                  (NBITS - 1) * CPB + CPB / 2 + 2, (NBITS - 1) * CPB + CPB / 2 + 8);
      check("a5_valid_width", 32'(last_width), 32'd1);

      // Parity: wrong bit, right bit, then odd parity.
      base = n_acc;
      tx(8'h3C, 1'b1, 2'b11, 1, 1'b0);
      wait_acc(base + 1);
      check("3c_bad_parity_flags", 32'(last_flags), 32'b100);
      tx(8'h3C, 1'b0, 2'b11, 1, 1'b0);
      wait_acc(base + 2);
      check("3c_good_parity_flags", 32'(last_flags), 32'b000);
      ptype = PARITY_ODD;
      tx(8'h3C, 1'b1, 2'b11, 1, 1'b0);
      wait_acc(base + 3);
      check("3c_odd_parity_flags", 32'(last_flags), 32'b000);
      ptype = PARITY_EVEN;

      // Short low glitch on the idle line is a false start.
      base = n_acc;
      serial = 1'b0;
      repeat (3) @(negedge clk);
      serial = 1'b1;
      saw = 1'b0;
      n = 0;
      while (n < CPB / 2 + 3 && !(saw && !busy)) begin
         @(negedge clk);
         n++;
         if (busy) saw = 1'b1;
      end
      check("glitch_busy_rose", 32'(saw), 32'd1);
      check("glitch_busy_cleared", 32'(busy), 32'd0);
      idle_bits(2);
      check("glitch_no_frame", 32'(n_acc - base), 32'd0);

      // One-cycle glitch at a data bit's sample point is voted away.
      base = n_acc;
      exp_q.push_back(model(8'h81, 1'b0, ptype, 2'b11, 1'b0));
      send_frame(8'h81, 1'b0, 2'b11, 3, -1);
      idle_bits(1);
      wait_acc(base + 1);
      check("glitch_data", 32'(last_data), 32'h081);

      // Overrun: consumer stalled across two frames.
      base = n_acc;
      n = ovr_seen;
      set_ready(1'b0);
      tx(8'h11, 1'b0, 2'b11, 0, 1'b0);
      tx(8'h22, 1'b0, 2'b11, 1, 1'b1);
      check("ovr_pulses", 32'(ovr_seen - n), 32'd1);
      check("ovr_valid_held", 32'(bus.data_valid), 32'd1);
      check("ovr_data_held", 32'(bus.parallel_dataout), 32'h011);
      set_ready(1'b1);
      wait_acc(base + 1);
      check("ovr_accepted_data", 32'(last_data), 32'h011);
      check("ovr_valid_cleared", 32'(bus.data_valid), 32'd0);
      idle_bits(1);
      check("ovr_single_accept", 32'(n_acc - base), 32'd1);

      // Break: line low for two frame times.
      base = n_acc;
      exp_q.push_back(model('0, 1'b0, ptype, 2'b00, 1'b0));
      serial = 1'b0;
      repeat (2 * NBITS * CPB) @(negedge clk);
      check("break_one_frame", 32'(n_acc - base), 32'd1);
      check("break_flags", 32'(last_flags), 32'b011);
      check("break_data", 32'(last_data), 32'd0);
      check("break_waits_high", 32'(busy), 32'd1);
      idle_bits(2);
      check("break_released", 32'(busy), 32'd0);
      tx(8'h5E, 1'b1, 2'b11, 1, 1'b0);
      wait_acc(base + 2);
      check("after_break_data", 32'(last_data), 32'h05E);

      // Reset during data bit 4 of 0x5A.
      base = n_acc;
      send_frame(8'h5A, 1'b0, 2'b11, -1, 5);
      rst = 1'b1;
      serial = 1'b1;
      repeat (2) @(negedge clk);
      check_reset_outputs("midreset");
      rst = 1'b0;
      idle_bits(2);
      tx(8'hC3, 1'b0, 2'b11, 1, 1'b0);
      wait_acc(base + 1);
      check("midreset_only_c3", 32'(n_acc - base), 32'd1);
      check("midreset_c3_data", 32'(last_data), 32'h0C3);
      check("midreset_c3_flags", 32'(last_flags), 32'd0);

      // Randomized frames with a randomly stalling consumer.
      ready_rand = 1'b1;
      for (int f = 0; f < 30; f++) begin
         d     = DL'($urandom);
         ptype = 1'($urandom_range(0, 1));
         p     = ($urandom_range(0, 3) == 0) ? ~good_par(d, ptype) : good_par(d, ptype);
         st    = ($urandom_range(0, 5) == 0) ? 2'b00 : 2'b11;
         gap   = (st[0] == 1'b0) ? $urandom_range(1, 2) : $urandom_range(0, 2);
         tx(d, p, st, gap, 1'b0);
      end
      ready_rand = 1'b0;
      set_ready(1'b1);
      idle_bits(3);
      check("queue_drained", 32'(exp_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
